// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and register-file writeback driver with forwarding tap and retire counter.
// Optional sub-word load extraction is enabled by defining WB_SUBWORD_LOAD_EN.
module mem_wb_writeback #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic             RegWrite_i,
    input  logic             MemtoReg_i,
    input  logic [4:0]       RDaddr_i,
    input  logic [XLEN-1:0]  ALUResult_i,
    input  logic [XLEN-1:0]  MemData_i,
    input  logic [2:0]       funct3_i,
    output logic [4:0]       RDaddr_o,
    output logic [XLEN-1:0]  RDdata_o,
    output logic             RegWrite_o,
    output logic             fwd_valid_o,
    output logic [CNT_W-1:0] retire_cnt_o
);

    logic             wb_valid_q, wb_valid_d;
    logic             wb_regwrite_q, wb_regwrite_d;
    logic             wb_memtoreg_q, wb_memtoreg_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]  wb_alu_q, wb_alu_d;
    logic [XLEN-1:0]  wb_mem_q, wb_mem_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic             retire;
    logic [XLEN-1:0]  load_val;
`ifdef WB_SUBWORD_LOAD_EN
    logic [2:0]       wb_f3_q, wb_f3_d;
    logic [1:0]       wb_off_q, wb_off_d;
`else
    logic             unused_f3;
    assign unused_f3 = ^funct3_i;
`endif

    // An instruction retires when it leaves WB: valid, not held, not squashed.
    always_comb begin
        wb_valid_d    = wb_valid_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_memtoreg_d = wb_memtoreg_q;
        wb_rd_d       = wb_rd_q;
        wb_alu_d      = wb_alu_q;
        wb_mem_d      = wb_mem_q;
`ifdef WB_SUBWORD_LOAD_EN
        wb_f3_d       = wb_f3_q;
        wb_off_d      = wb_off_q;
`endif
        retire = wb_valid_q & ~stall_i & ~flush_i;
        if (flush_i) begin
            wb_valid_d    = 1'b0;
            wb_regwrite_d = 1'b0;
        end else if (!stall_i) begin
            wb_valid_d    = valid_i;
            wb_regwrite_d = RegWrite_i & valid_i;
            wb_memtoreg_d = MemtoReg_i;
            wb_rd_d       = RDaddr_i;
            wb_alu_d      = ALUResult_i;
            wb_mem_d      = MemData_i;
`ifdef WB_SUBWORD_LOAD_EN
            wb_f3_d       = funct3_i;
            wb_off_d      = ALUResult_i[1:0];
`endif
        end
        retire_cnt_d = retire_cnt_q + CNT_W'(retire);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            wb_rd_q       <= '0;
            wb_alu_q      <= '0;
            wb_mem_q      <= '0;
            retire_cnt_q  <= '0;
`ifdef WB_SUBWORD_LOAD_EN
            wb_f3_q       <= '0;
            wb_off_q      <= '0;
`endif
        end else begin
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_memtoreg_q <= wb_memtoreg_d;
            wb_rd_q       <= wb_rd_d;
            wb_alu_q      <= wb_alu_d;
            wb_mem_q      <= wb_mem_d;
            retire_cnt_q  <= retire_cnt_d;
`ifdef WB_SUBWORD_LOAD_EN
            wb_f3_q       <= wb_f3_d;
            wb_off_q      <= wb_off_d;
`endif
        end
    end

`ifdef WB_SUBWORD_LOAD_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Misaligned halves ignore off[0] and take the half selected by off[1].
    always_comb begin
        ld_byte  = wb_mem_q[{wb_off_q, 3'b000} +: 8];
        ld_half  = wb_mem_q[{wb_off_q[1], 4'b0000} +: 16];
        load_val = wb_mem_q;
        case (wb_f3_q)
            3'b000:  load_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  load_val = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, ld_half};
            default: load_val = wb_mem_q;
        endcase
    end
`else
    assign load_val = wb_mem_q;
`endif

    assign RegWrite_o   = wb_valid_q & wb_regwrite_q & (wb_rd_q != 5'd0);
    assign fwd_valid_o  = RegWrite_o;
    assign RDaddr_o     = wb_rd_q;
    assign RDdata_o     = wb_memtoreg_q ? load_val : wb_alu_q;
    assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Randomized and directed bench for mem_wb_writeback against a behavioural writeback model.
module tb_mem_wb_writeback;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 0, flush = 0, valid = 0, rw = 0, mtr = 0;
    logic [4:0]  rd = '0;
    logic [31:0] alu = '0, mem = '0;
    logic [2:0]  f3 = '0;
    logic [4:0]  rd_o;
    logic [31:0] data_o;
    logic        we_o, fwd_o;
    logic [CW-1:0] cnt_o;

    int vecs = 0, errs = 0;
    bit chk_en = 0;

    // model of the instruction sitting in WB
    bit          m_valid, m_rw, m_mtr;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_mem;
    logic [2:0]  m_f3;
    int          m_cnt;

    mem_wb_writeback #(.XLEN(32), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush),
        .valid_i(valid), .RegWrite_i(rw), .MemtoReg_i(mtr), .RDaddr_i(rd),
        .ALUResult_i(alu), .MemData_i(mem), .funct3_i(f3),
        .RDaddr_o(rd_o), .RDdata_o(data_o), .RegWrite_o(we_o),
        .fwd_valid_o(fwd_o), .retire_cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] load_model(input logic [31:0] w, input logic [2:0] fn,
                                               input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'((w >> (8 * int'(off))) & 32'hFF);
        h = 16'((w >> (off[1] ? 16 : 0)) & 32'hFFFF);
`ifdef WB_SUBWORD_LOAD_EN
        case (fn)
            3'd0: return 32'($signed(b));
            3'd1: return 32'($signed(h));
            3'd4: return 32'(b);
            3'd5: return 32'(h);
            default: return w;
        endcase
`else
        return w;
`endif
    endfunction

    function automatic bit exp_we();
        return m_valid && m_rw && (m_rd != 0);
    endfunction

    function automatic logic [31:0] exp_data();
        return m_mtr ? load_model(m_mem, m_f3, m_alu[1:0]) : m_alu;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mtr = 0; m_rd = 0; m_alu = 0; m_mem = 0; m_f3 = 0; m_cnt = 0;
    endtask

    // One clock: model consumes the inputs seen at the edge, returns at the following negedge.
    task automatic cycle();
        @(posedge clk);
        if (m_valid && !stall && !flush) m_cnt = (m_cnt + 1) % (1 << CW);
        if (flush) begin
            m_valid = 0; m_rw = 0;
        end else if (!stall) begin
            m_valid = valid; m_rw = rw && valid; m_mtr = mtr; m_rd = rd;
            m_alu = alu; m_mem = mem; m_f3 = f3;
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input bit w, input bit mt, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] md, input logic [2:0] fn);
        valid = v; rw = w; mtr = mt; rd = r; alu = a; mem = md; f3 = fn;
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("we", 32'(we_o), 32'(exp_we()));
            check("fwd", 32'(fwd_o), 32'(exp_we()));
            check("rd", 32'(rd_o), 32'(m_rd));
            check("data", data_o, exp_data());
            check("cnt", 32'(cnt_o), 32'(m_cnt));
        end
    end

    localparam logic [31:0] LW_WORD = 32'h80FF_7F81;

    initial begin
        logic [31:0] ld_exp [5];
        logic [2:0]  ld_f3  [5];
        logic [1:0]  ld_off [5];
        int guard;
        ld_f3  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        ld_off = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0};
`ifdef WB_SUBWORD_LOAD_EN
        ld_exp = '{32'hFFFF_FF81, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_80FF, LW_WORD};
`else
        ld_exp = '{LW_WORD, LW_WORD, LW_WORD, LW_WORD, LW_WORD};
`endif
        model_reset();
        #12;
        check("rst_we", 32'(we_o), 32'h0);
        check("rst_rd", 32'(rd_o), 32'h0);
        check("rst_data", data_o, 32'h0);
        check("rst_cnt", 32'(cnt_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1;

        // basic ALU writeback
        drive(1, 1, 0, 5'd5, 32'h0000_1234, 32'h0, 3'd2);
        cycle();
        check("alu_we", 32'(we_o), 32'h1);
        check("alu_rd", 32'(rd_o), 32'd5);
        check("alu_data", data_o, 32'h1234);
        check("alu_cnt0", 32'(cnt_o), 32'd0);
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 3'd0);
        cycle();
        check("alu_cnt1", 32'(cnt_o), 32'd1);

        // x0 destination: suppressed write, still retired
        drive(1, 1, 0, 5'd0, 32'hFFFF_FFFF, 32'h0, 3'd0);
        cycle();
        check("x0_we", 32'(we_o), 32'h0);
        check("x0_rd", 32'(rd_o), 32'h0);
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 3'd0);
        cycle();
        check("x0_cnt", 32'(cnt_o), 32'd2);

        // stall holds rd=7 for 3 cycles, counted once
        drive(1, 1, 0, 5'd7, 32'h0000_0077, 32'h0, 3'd0);
        cycle();
        stall = 1;
        drive(1, 1, 0, 5'd9, 32'hDEAD_BEEF, 32'h0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_we", 32'(we_o), 32'h1);
            check("stall_rd", 32'(rd_o), 32'd7);
            check("stall_data", data_o, 32'h77);
            check("stall_cnt", 32'(cnt_o), 32'd2);
        end
        stall = 0;
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 3'd0);
        cycle();
        check("stall_cnt_after", 32'(cnt_o), 32'd3);

        // flush beats stall
        drive(1, 1, 0, 5'd9, 32'h0000_0999, 32'h0, 3'd0);
        cycle();
        check("pre_flush_we", 32'(we_o), 32'h1);
        flush = 1; stall = 1;
        cycle();
        check("flush_we", 32'(we_o), 32'h0);
        check("flush_cnt", 32'(cnt_o), 32'd3);
        flush = 0; stall = 0;

        // load extraction cases
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, 5'd10, {30'h0000_1000, ld_off[i]}, LW_WORD, ld_f3[i]);
            cycle();
            check("load_data", data_o, ld_exp[i]);
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 99) < 20);
            flush = ($urandom_range(0, 99) < 10);
            drive(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom,
                  3'($urandom));
            cycle();
        end

        // run the counter up to its wrap point
        stall = 0; flush = 0;
        drive(1, 1, 0, 5'd3, 32'h1, 32'h0, 3'd0);
        guard = 0;
        while (!(m_cnt == (1 << CW) - 1 && m_valid) && guard < 600) begin
            cycle();
            guard++;
        end
        check("wrap_reach", 32'(guard < 600), 32'h1);
        check("wrap_pre", 32'(cnt_o), 32'((1 << CW) - 1));
        cycle();
        check("wrap_zero", 32'(cnt_o), 32'h0);

        // asynchronous reset mid-stream with a valid write in WB
        drive(1, 1, 1, 5'd12, 32'h0, LW_WORD, 3'd2);
        cycle();
        check("pre_rst_we", 32'(we_o), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_we", 32'(we_o), 32'h0);
        check("arst_fwd", 32'(fwd_o), 32'h0);
        check("arst_rd", 32'(rd_o), 32'h0);
        check("arst_data", data_o, 32'h0);
        check("arst_cnt", 32'(cnt_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 3'd0);
        cycle();
        check("post_rst_cnt", 32'(cnt_o), 32'h0);
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
